// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: DEPTH-entry FIFO of {misalign, pc, inst} slots
// between fetch and decode, with valid/ready handshake and redirect flush.
module inst_fetch_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fetch_v,
   input  logic [31:0]              fetch_pc,
   input  logic [31:0]              fetch_inst,
   output logic                     fetch_ready,
   input  logic                     flush,
   output logic                     dec_v,
   output logic [31:0]              dec_pc,
   output logic [31:0]              dec_inst,
   output logic                     dec_misalign,
   input  logic                     dec_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic        misalign;
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              push;
   logic              pop;

   // Handshake flags depend only on state, never on dec_ready or fetch_v.
   assign fetch_ready = (count != CNT_W'(DEPTH));
   assign dec_v       = (count != CNT_W'(0));
   assign push        = fetch_v & fetch_ready & ~flush;
   assign pop         = dec_v & dec_ready & ~flush;

   assign dec_pc       = mem[rd_ptr].pc;
   assign dec_inst     = mem[rd_ptr].inst;
   assign dec_misalign = mem[rd_ptr].misalign;

   // Entry storage; flush leaves contents in place, reset clears them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= '{misalign: (fetch_pc[1:0] != 2'b00),
                          pc:       fetch_pc,
                          inst:     fetch_inst};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_inst_fetch_buffer;

   localparam int unsigned DEPTH = 4;

   logic        clk;
   logic        reset_n;
   logic        fetch_v;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_inst;
   logic        fetch_ready;
   logic        flush;
   logic        dec_v;
   logic [31:0] dec_pc;
   logic [31:0] dec_inst;
   logic        dec_misalign;
   logic        dec_ready;
   logic [$clog2(DEPTH):0] count;

   inst_fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .fetch_v      (fetch_v),
      .fetch_pc     (fetch_pc),
      .fetch_inst   (fetch_inst),
      .fetch_ready  (fetch_ready),
      .flush        (flush),
      .dec_v        (dec_v),
      .dec_pc       (dec_pc),
      .dec_inst     (dec_inst),
      .dec_misalign (dec_misalign),
      .dec_ready    (dec_ready),
      .count        (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] pc);
      return (pc * 32'd2654435761) ^ 32'h1357_9bdf;
   endfunction

   task automatic check_all();
      chk("count", 64'(count), 64'(q.size()));
      chk("fetch_ready", 64'(fetch_ready), 64'(q.size() < DEPTH));
      chk("dec_v", 64'(dec_v), 64'(q.size() != 0));
      if (q.size() != 0) begin
         chk("dec_pc", 64'(dec_pc), 64'(q[0].pc));
         chk("dec_inst", 64'(dec_inst), 64'(q[0].inst));
         chk("dec_misalign", 64'(dec_misalign), 64'(q[0].pc[1:0] != 2'b00));
      end
   endtask

   // One clock: drive inputs, advance model from the rules, compare after edge.
   task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] inst,
                      input logic fl, input logic dr);
      bit do_push;
      bit do_pop;
      ent_t e;
      fetch_v    = fv;
      fetch_pc   = pc;
      fetch_inst = inst;
      flush      = fl;
      dec_ready  = dr;
      do_push = fv && (q.size() < DEPTH) && !fl;
      do_pop  = (q.size() != 0) && dr && !fl;
      @(posedge clk);
      #1;
      if (fl) begin
         q.delete();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.pc   = pc;
            e.inst = inst;
            q.push_back(e);
         end
      end
      check_all();
   endtask

   task automatic fetch(input logic [31:0] pc, input logic dr);
      cyc(1'b1, pc, word_of(pc), 1'b0, dr);
   endtask

   task automatic idle(input logic dr);
      cyc(1'b0, 32'h0, 32'h0, 1'b0, dr);
   endtask

   task automatic check_reset_state();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_dec_v", 64'(dec_v), 64'd0);
      chk("rst_fetch_ready", 64'(fetch_ready), 64'd1);
      chk("rst_dec_pc", 64'(dec_pc), 64'd0);
      chk("rst_dec_inst", 64'(dec_inst), 64'd0);
      chk("rst_dec_misalign", 64'(dec_misalign), 64'd0);
   endtask

   initial begin
      reset_n    = 1'b0;
      fetch_v    = 1'b0;
      fetch_pc   = '0;
      fetch_inst = '0;
      flush      = 1'b0;
      dec_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state();
      reset_n = 1'b1;

      // Three pushes held without decode.
      fetch(32'h0, 1'b0);
      fetch(32'h4, 1'b0);
      fetch(32'h8, 1'b0);
      chk("three_count", 64'(count), 64'd3);
      chk("three_pc", 64'(dec_pc), 64'd0);
      chk("three_inst", 64'(dec_inst), 64'(word_of(32'h0)));
      chk("three_ready", 64'(fetch_ready), 64'd1);

      // Fill, then a refused 5th slot, then drain in order.
      fetch(32'hC, 1'b0);
      chk("full_ready", 64'(fetch_ready), 64'd0);
      fetch(32'h10, 1'b1);
      chk("full_no_push_on_pop", 64'(count), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk("drain_pc", 64'(dec_pc), 64'(32'h4 * (i + 1)));
         idle(1'b1);
      end
      chk("drained_v", 64'(dec_v), 64'd0);
      idle(1'b1);
      chk("empty_no_underflow", 64'(count), 64'd0);

      // Steady stream, then with decode toggling.
      for (int i = 0; i < 16; i++) begin
         fetch(32'(i * 4), 1'b1);
         chk("stream_count", 64'(count), 64'd1);
      end
      idle(1'b1);
      for (int i = 0; i < 16; i++) fetch(32'(i * 4), 1'(i % 2 == 0));
      while (q.size() != 0) idle(1'b1);

      // Flush with concurrent push and pop.
      fetch(32'h40, 1'b0);
      fetch(32'h44, 1'b0);
      fetch(32'h48, 1'b0);
      cyc(1'b1, 32'h200, word_of(32'h200), 1'b1, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_dec_v", 64'(dec_v), 64'd0);
      fetch(32'h100, 1'b0);
      chk("post_flush_pc", 64'(dec_pc), 64'h100);

      // Misaligned PC flagging.
      idle(1'b1);
      fetch(32'h102, 1'b0);
      chk("misalign_set", 64'(dec_misalign), 64'd1);
      fetch(32'h104, 1'b1);
      chk("misalign_clr", 64'(dec_misalign), 64'd0);
      chk("misalign_next_pc", 64'(dec_pc), 64'h104);
      idle(1'b1);

      // Asynchronous reset between edges with two entries held.
      fetch(32'h500, 1'b0);
      fetch(32'h504, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      q.delete();
      check_reset_state();
      @(negedge clk);
      reset_n = 1'b1;
      fetch(32'h300, 1'b0);
      fetch(32'h304, 1'b1);
      idle(1'b1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] pc;
         pc = $urandom();
         if ($urandom_range(0, 7) != 0) pc[1:0] = 2'b00;
         cyc(1'($urandom_range(0, 9) < 7), pc, $urandom(),
             1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Receiving end of the instruction fetch stream. It captures each valid fetch slot (PC plus instruction word) from the PC generator and instruction memory, and holds it in a DEPTH-entry FIFO. It presents entries in order to decode over a valid/ready handshake, and back-pressures fetch when full. A redirect discards everything buffered. It sits between fetch (pc_i / inst_v_i stage) and decode.

## Interface
- DEPTH, 4, number of buffer entries; power of two, ≥2
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- fetch_v  in  1  fetch slot valid (driven from inst_v_i)
- fetch_pc  in  32  PC of the fetch slot (pc_i)
- fetch_inst  in  32  instruction word read from imem for fetch_pc
- fetch_ready  out  1  buffer accepts a slot this cycle
- flush  in  1  redirect; discard all buffered and incoming entries
- dec_v  out  1  head entry valid
- dec_pc  out  32  PC of head entry
- dec_inst  out  32  instruction of head entry
- dec_misalign  out  1  head entry had fetch_pc[1:0] != 0
- dec_ready  in  1  decode consumes head entry this cycle
- count  out  $clog2(DEPTH)+1  number of valid entries

## Operation
- Storage: DEPTH entries of {misalign, pc[31:0], inst[31:0]}, with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH, plus count.
- fetch_ready = (count != DEPTH). Purely from state, so there is no combinational path from dec_ready or fetch_v.
- push = fetch_v & fetch_ready & !flush. It writes {fetch_pc[1:0]!=0, fetch_pc, fetch_inst} at wr_ptr, then wr_ptr+1.
- pop = dec_v & dec_ready & !flush. It advances rd_ptr.
- count next: +1 on push only, −1 on pop only, unchanged on both or neither.
- dec_v = (count != 0). dec_pc, dec_inst and dec_misalign read the entry at rd_ptr directly. This is not fall-through: an empty buffer never bypasses fetch inputs.
- Full: the push is refused even if a pop happens in the same cycle. fetch_v while full is dropped, and holding it is the PC generator's responsibility.
- Empty: dec_ready is ignored and count never underflows.
- flush: on the next edge, count = 0 and wr_ptr = rd_ptr = 0. Any push or pop in the flush cycle is discarded. Entry contents are not cleared.
- Misaligned PCs are buffered normally and flagged. Decode raises the exception.
- Entries leave in strict push order, and each is delivered exactly once.

## Timing
- Reset (reset_n low, asynchronous): count = 0 and wr_ptr = rd_ptr = 0, so dec_v = 0 and fetch_ready = 1. All storage is cleared, so dec_pc, dec_inst and dec_misalign read 0. This holds while reset_n is low.
- Reset mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Latency: a slot pushed at edge N is visible as dec_v = 1 from just after edge N. It is popped no earlier than edge N+1.
- Throughput: with dec_ready held high, one entry per cycle with steady count.
- fetch_ready falls right after the edge that makes count = DEPTH. It rises right after the first edge that pops without pushing.
- flush has priority over push and pop in the same cycle.

## Test plan
- Reset, then fetch_v = 1 with pc 0, 4, 8 and dec_ready = 0 → count 3; dec_pc = 0, dec_inst = word@0; fetch_ready = 1.
- Push DEPTH=4 slots with dec_ready = 0, then a 5th at pc 0x10 → fetch_ready = 0 after the 4th edge; 0x10 is not stored; count stays 4; drain yields pc 0, 4, 8, 0xC in order.
- Steady stream pc 0..0x3C with dec_ready = 1 every cycle → count stays 1 after the first push; decode sees 16 PCs in order with no gaps or duplicates. Then repeat with dec_ready toggling 1/0 → same order, nothing lost, and the pointers wrap correctly past entry 3.
- With 3 entries held, assert flush together with fetch_v and dec_ready → next cycle count = 0 and dec_v = 0; the slot from the flush cycle is absent; the next push at pc 0x100 appears as dec_pc = 0x100.
- Push pc 0x102 → dec_misalign = 1 with dec_pc = 0x102. The following pc 0x104 → dec_misalign = 0.
- Drop reset_n between edges with 2 entries held → dec_v = 0, count = 0 and fetch_ready = 1 immediately. After release, normal pushes resume at wr_ptr 0.
